// File: rtl/ntt_butterfly.sv
// -----------------------------------------------------------------------------
// ntt_butterfly
//
// Pipelined radix-2 modular butterfly over Z_Q for the NTT datapath.
// Accepts one butterfly per clock and produces it five register stages later.
// There is no backpressure.
//
//   Cooley-Tukey (CT):     x = (a + b*w) mod Q,  y = (a - b*w) mod Q
//   Gentleman-Sande (GS):  x = (a + b) mod Q,    y = ((a - b)*w) mod Q
//
// The modular product is reduced with Barrett reduction. MU is derived
// locally from Q. The additive operand travels beside the multiplier so that
// both operands line up at the final add/sub stage. That operand is a in CT
// mode and (a+b) mod Q in GS mode.
//
// Configuration macro: BF_GS_EN
//   defined   : the GS path is built in, and in_mode selects CT or GS for each
//               transaction. The mode travels with the data.
//   undefined : in_mode is ignored and every transaction is CT. The stage-1
//               add/sub logic and the mode pipeline are not built.
//               Latency and the port list do not change.
//
// Parameters:
//   DATA : coefficient width in bits
//   Q    : odd modulus with 2^(DATA-1) < Q < 2^DATA
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high; clears every pipeline register
//   in_valid  in   in_a/in_b/in_w/in_mode are valid this cycle
//   in_mode   in   0 = CT, 1 = GS (only with BF_GS_EN)
//   in_a      in   DATA bits, operand a (< Q)
//   in_b      in   DATA bits, operand b (< Q)
//   in_w      in   DATA bits, twiddle   (< Q)
//   out_valid out  out_x/out_y are valid
//   out_x     out  DATA bits, first result in [0, Q)
//   out_y     out  DATA bits, second result in [0, Q)
// -----------------------------------------------------------------------------
module ntt_butterfly #(
  parameter int unsigned     DATA = 32,
  parameter longint unsigned Q    = 64'd3221225473
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            in_mode,
  input  logic [DATA-1:0] in_a,
  input  logic [DATA-1:0] in_b,
  input  logic [DATA-1:0] in_w,
  output logic            out_valid,
  output logic [DATA-1:0] out_x,
  output logic [DATA-1:0] out_y
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [DATA-1:0]   QD      = Q[DATA-1:0];
  localparam logic [DATA:0]     Q1      = {1'b0, QD};
  localparam logic [DATA+1:0]   Q2      = {2'b00, QD};
  // MU = floor(2^(2*DATA) / Q). This value fits in DATA+1 bits because
  // Q > 2^(DATA-1).
  localparam logic [2*DATA:0]   POW2    = {1'b1, {(2*DATA){1'b0}}};
  localparam logic [2*DATA:0]   MU_FULL = POW2 / {{(DATA+1){1'b0}}, QD};
  localparam logic [DATA:0]     MU      = MU_FULL[DATA:0];

  // ---------------------------------------------------------------------------
  // Stage 1: capture inputs (plus s/d pre-sums in GS builds)
  // ---------------------------------------------------------------------------
  logic            s1_valid;
  logic [DATA-1:0] s1_a;
  logic [DATA-1:0] s1_b;
  logic [DATA-1:0] s1_w;

`ifdef BF_GS_EN
  logic            s1_mode;
  logic [DATA-1:0] s1_s;
  logic [DATA-1:0] s1_d;
  logic [DATA:0]   pre_sum;
  logic [DATA:0]   pre_diff;
  logic [DATA-1:0] s_next;
  logic [DATA-1:0] d_next;

  always_comb begin
    pre_sum  = {1'b0, in_a} + {1'b0, in_b};
    pre_diff = {1'b0, in_a} - {1'b0, in_b};
    s_next   = (pre_sum >= Q1) ? DATA'(pre_sum - Q1) : DATA'(pre_sum);
    // The MSB of the one-bit-wider difference is the borrow. Adding Q then
    // wraps the value back into [0, Q).
    d_next   = pre_diff[DATA] ? DATA'(pre_diff + Q1) : DATA'(pre_diff);
  end
`else
  // Mode has no effect in a CT-only build.
  logic unused_mode;
  assign unused_mode = in_mode;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_w     <= '0;
`ifdef BF_GS_EN
      s1_mode  <= 1'b0;
      s1_s     <= '0;
      s1_d     <= '0;
`endif
    end else begin
      s1_valid <= in_valid;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_w     <= in_w;
`ifdef BF_GS_EN
      s1_mode  <= in_mode;
      s1_s     <= s_next;
      s1_d     <= d_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: full-width product p = m1 * w
  // ---------------------------------------------------------------------------
  logic [DATA-1:0]   mul_op;
  logic [DATA-1:0]   carry_op;
  logic [2*DATA-1:0] p_next;

  always_comb begin
`ifdef BF_GS_EN
    mul_op   = s1_mode ? s1_d : s1_b;
    carry_op = s1_mode ? s1_s : s1_a;
`else
    mul_op   = s1_b;
    carry_op = s1_a;
`endif
    p_next = {{DATA{1'b0}}, mul_op} * {{DATA{1'b0}}, s1_w};
  end

  logic              s2_valid;
  logic [2*DATA-1:0] s2_p;
  logic [DATA-1:0]   s2_c;
`ifdef BF_GS_EN
  logic              s2_mode;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_p     <= '0;
      s2_c     <= '0;
`ifdef BF_GS_EN
      s2_mode  <= 1'b0;
`endif
    end else begin
      s2_valid <= s1_valid;
      s2_p     <= p_next;
      s2_c     <= carry_op;
`ifdef BF_GS_EN
      s2_mode  <= s1_mode;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: Barrett quotient estimate qh = ((p >> (DATA-1)) * MU) >> (DATA+1)
  // ---------------------------------------------------------------------------
  logic [DATA:0]     p_hi;
  logic [2*DATA+1:0] qh_prod;
  logic [DATA:0]     qh_next;

  always_comb begin
    p_hi    = s2_p[2*DATA-1:DATA-1];
    qh_prod = {{(DATA+1){1'b0}}, p_hi} * {{(DATA+1){1'b0}}, MU};
    qh_next = (DATA+1)'(qh_prod >> (DATA+1));
  end

  logic            s3_valid;
  logic [DATA:0]   s3_qh;
  // qh underestimates floor(p/Q) by at most 2, so p - qh*Q < 3Q < 2^(DATA+2).
  // Only the low DATA+2 bits of p are needed from this point on.
  logic [DATA+1:0] s3_p;
  logic [DATA-1:0] s3_c;
`ifdef BF_GS_EN
  logic            s3_mode;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_valid <= 1'b0;
      s3_qh    <= '0;
      s3_p     <= '0;
      s3_c     <= '0;
`ifdef BF_GS_EN
      s3_mode  <= 1'b0;
`endif
    end else begin
      s3_valid <= s2_valid;
      s3_qh    <= qh_next;
      s3_p     <= s2_p[DATA+1:0];
      s3_c     <= s2_c;
`ifdef BF_GS_EN
      s3_mode  <= s2_mode;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 4: remainder r = p - qh*Q on DATA+2 bits, then up to two -Q folds
  // ---------------------------------------------------------------------------
  logic [2*DATA+1:0] qhq_full;
  logic [DATA+1:0]   rem0;
  logic [DATA+1:0]   rem1;
  logic [DATA+1:0]   rem2;
  logic [DATA-1:0]   m_next;

  always_comb begin
    qhq_full = {{(DATA+1){1'b0}}, s3_qh} * {{(DATA+2){1'b0}}, QD};
    // Modular arithmetic on DATA+2 bits is exact because the true remainder
    // fits in that width.
    rem0   = s3_p - (DATA+2)'(qhq_full);
    rem1   = (rem0 >= Q2) ? rem0 - Q2 : rem0;
    rem2   = (rem1 >= Q2) ? rem1 - Q2 : rem1;
    m_next = DATA'(rem2);
  end

  logic            s4_valid;
  logic [DATA-1:0] s4_m;
  logic [DATA-1:0] s4_c;
`ifdef BF_GS_EN
  logic            s4_mode;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s4_valid <= 1'b0;
      s4_m     <= '0;
      s4_c     <= '0;
`ifdef BF_GS_EN
      s4_mode  <= 1'b0;
`endif
    end else begin
      s4_valid <= s3_valid;
      s4_m     <= m_next;
      s4_c     <= s3_c;
`ifdef BF_GS_EN
      s4_mode  <= s3_mode;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 5: final add/sub (CT) or pass-through (GS)
  // ---------------------------------------------------------------------------
  logic [DATA:0]   fin_sum;
  logic [DATA:0]   fin_diff;
  logic [DATA-1:0] x_ct;
  logic [DATA-1:0] y_ct;
  logic [DATA-1:0] x_next;
  logic [DATA-1:0] y_next;

  always_comb begin
    fin_sum  = {1'b0, s4_c} + {1'b0, s4_m};
    fin_diff = {1'b0, s4_c} - {1'b0, s4_m};
    x_ct     = (fin_sum >= Q1) ? DATA'(fin_sum - Q1) : DATA'(fin_sum);
    y_ct     = fin_diff[DATA] ? DATA'(fin_diff + Q1) : DATA'(fin_diff);
    x_next   = x_ct;
    y_next   = y_ct;
`ifdef BF_GS_EN
    if (s4_mode) begin
      x_next = s4_c;
      y_next = s4_m;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= s4_valid;
      out_x     <= x_next;
      out_y     <= y_next;
    end
  end

endmodule

// File: tb/tb_ntt_butterfly.sv
// -----------------------------------------------------------------------------
// tb_ntt_butterfly
//
// Self-checking bench for ntt_butterfly with DATA=14 and Q=12289.
// Every driven cycle pushes one expected entry to a scoreboard queue. Bubbles
// are pushed as entries with v=0. The queue is primed with four idle entries,
// so each entry is popped and compared exactly five cycles after it was
// driven. Expected values come from directed constants or from a plain modular
// reference model. Honours BF_GS_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_ntt_butterfly;

  localparam int     DATA = 14;
  localparam longint QV   = 12289;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_mode = 1'b0;
  logic [DATA-1:0] in_a = '0;
  logic [DATA-1:0] in_b = '0;
  logic [DATA-1:0] in_w = '0;
  logic            out_valid;
  logic [DATA-1:0] out_x;
  logic [DATA-1:0] out_y;

  ntt_butterfly #(.DATA(DATA), .Q(64'd12289)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_mode   (in_mode),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_w      (in_w),
    .out_valid (out_valid),
    .out_x     (out_x),
    .out_y     (out_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            v;
    logic [DATA-1:0] x;
    logic [DATA-1:0] y;
    int              id;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   txn_id     = 0;

  // Reference model: straightforward modular arithmetic, no Barrett.
  function automatic void model(input logic mode, input int a, input int b,
                                input int w, output int x, output int y);
    longint t;
    logic   m;
    m = mode;
`ifndef BF_GS_EN
    m = 1'b0;
`endif
    if (!m) begin
      t = (longint'(b) * longint'(w)) % QV;
      x = int'((longint'(a) + t) % QV);
      y = int'((longint'(a) - t + QV) % QV);
    end else begin
      x = int'((longint'(a) + longint'(b)) % QV);
      t = (longint'(a) - longint'(b) + QV) % QV;
      y = int'((t * longint'(w)) % QV);
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic preload();
    sb.delete();
    repeat (4) sb.push_back('{v: 1'b0, x: '0, y: '0, id: -1});
  endtask

  // Drive one cycle, push its expectation, then compare the entry due now.
  task automatic step(input logic v, input logic mode, input int a, input int b,
                      input int w, input int ex, input int ey);
    exp_t e;
    in_valid = v;
    in_mode  = mode;
    in_a     = DATA'(a);
    in_b     = DATA'(b);
    in_w     = DATA'(w);
    if (v) txn_id++;
    sb.push_back('{v: v, x: DATA'(ex), y: DATA'(ey), id: (v ? txn_id : -1)});
    @(posedge clk);
    #1;
    if (sb.size() >= 5) begin
      e = sb.pop_front();
      check("out_valid", {31'd0, out_valid}, {31'd0, e.v});
      if (e.v) begin
        check("out_x", {18'd0, out_x}, {18'd0, e.x});
        check("out_y", {18'd0, out_y}, {18'd0, e.y});
        $display("txn %0d: x=%0d (exp %0d) y=%0d (exp %0d)", e.id, out_x, e.x, out_y, e.y);
      end
    end
  endtask

  task automatic mstep(input logic mode, input int a, input int b, input int w);
    int ex, ey;
    model(mode, a, b, w, ex, ey);
    step(1'b1, mode, a, b, w, ex, ey);
  endtask

  task automatic idle();
    step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 12288)),
         int'($urandom_range(0, 12288)), int'($urandom_range(0, 12288)), 0, 0);
  endtask

  task automatic drain();
    repeat (5) idle();
  endtask

  task automatic check_reset_outputs();
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_x", {18'd0, out_x}, 32'd0);
    check("reset_y", {18'd0, out_y}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;

    // Power-up reset.
    #1 reset = 1'b1;
    #1 check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    preload();

    // CT basic and wrap cases.
    step(1'b1, 1'b0, 5, 3, 2, 11, 12288);
    drain();
    step(1'b1, 1'b0, 0, 12288, 12288, 1, 12288);
    step(1'b1, 1'b0, 12288, 1, 1, 0, 12287);
    drain();

    // GS cases. In a CT-only build, mode=1 must still give the CT result.
`ifdef BF_GS_EN
    step(1'b1, 1'b1, 5, 3, 2, 8, 4);
    step(1'b1, 1'b1, 3, 5, 1, 8, 12287);
`else
    step(1'b1, 1'b1, 5, 3, 2, 11, 12288);
`endif
    drain();

    // Streaming: 100 random transactions with random bubbles and mixed modes.
    n = 0;
    while (n < 100) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
      end else begin
        mstep(1'($urandom_range(0, 1)), int'($urandom_range(0, 12288)),
              int'($urandom_range(0, 12288)), int'($urandom_range(0, 12288)));
        n++;
      end
    end
    drain();

    // Reset while three transactions are in flight. They must never emerge.
    mstep(1'b0, 100, 200, 300);
    mstep(1'b1, 4000, 5000, 6000);
    mstep(1'b0, 12288, 12288, 2);
    reset    = 1'b1;
    in_valid = 1'b0;
    #1 check_reset_outputs();
    @(posedge clk);
    #1 check_reset_outputs();
    reset = 1'b0;
    preload();
    mstep(1'b0, 7, 9, 11);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
